// File: rtl/sd_spi_engine.sv
// SD card SPI byte sequencer behind the CPU data/command ports.
// Runs init, exchange, select and poll commands in SPI mode 0.
module sd_spi_engine #(
    parameter int SLOW_DIV   = 64,
    parameter int FAST_DIV   = 2,
    parameter int INIT_BYTES = 10,
    parameter int POLL_MAX   = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sd_signal,
    input  logic [1:0] sd_cmd,
    input  logic [7:0] sd_out,
    output logic [7:0] sd_din,
    output logic       sd_busy,
    output logic       sd_timeout,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DIV_MAX = ((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV) - 1;
    localparam int DW      = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    localparam logic [DW-1:0] SLOW_LIM  = DW'(SLOW_DIV - 1);
    localparam logic [DW-1:0] FAST_LIM  = DW'(FAST_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [7:0]    INIT_LAST = 8'(INIT_BYTES - 1);
    localparam logic [7:0]    POLL_LAST = 8'(POLL_MAX - 1);

    localparam logic [1:0] CMD_INIT = 2'd0;
    localparam logic [1:0] CMD_XCHG = 2'd1;
    localparam logic [1:0] CMD_SEL  = 2'd2;
    localparam logic [1:0] CMD_POLL = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_LO,
        BIT_HI,
        BYTE_END
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      cmd_q;
    logic [7:0]      tx_byte;
    logic [7:0]      shreg;
    logic [7:0]      rx_sh;
    logic [DW-1:0]   div_cnt;
    logic [DW-1:0]   div_lim;
    logic            slow_sel;
    logic [2:0]      bit_cnt;
    logic [7:0]      byte_cnt;
    logic [7:0]      load_byte;
    logic            accept;
    logic            phase_end;
    logic            last_bit;
    logic            poll_hit;
    logic            poll_out;
    logic            cmd_done;

    assign accept    = (state == IDLE) && sd_signal;
    assign div_lim   = slow_sel ? SLOW_LIM : FAST_LIM;
    assign phase_end = (div_cnt == div_lim);
    assign last_bit  = (bit_cnt == 3'd7);
    assign poll_hit  = (sd_din != 8'hFF);
    assign poll_out  = (byte_cnt == POLL_LAST);
    assign load_byte = (cmd_q == CMD_XCHG) ? tx_byte : 8'hFF;
    assign sd_busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and end-of-byte decision.
    always_comb begin
        state_next = state;
        cmd_done   = 1'b1;
        case (cmd_q)
            CMD_INIT: cmd_done = (byte_cnt == INIT_LAST);
            CMD_POLL: cmd_done = poll_hit || poll_out;
            default:  cmd_done = 1'b1;
        endcase
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (sd_cmd == CMD_SEL) ? BYTE_END : LOAD;
                end
            end
            LOAD: state_next = BIT_LO;
            BIT_LO: begin
                if (phase_end) begin
                    state_next = BIT_HI;
                end
            end
            BIT_HI: begin
                if (phase_end) begin
                    state_next = last_bit ? BYTE_END : BIT_LO;
                end
            end
            BYTE_END: state_next = cmd_done ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: command latch, divider, shift registers, pins and status.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cmd_q      <= CMD_INIT;
            tx_byte    <= 8'hFF;
            shreg      <= 8'hFF;
            rx_sh      <= 8'hFF;
            div_cnt    <= '0;
            slow_sel   <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
            sd_din     <= 8'hFF;
            sd_timeout <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q      <= sd_cmd;
                        tx_byte    <= sd_out;
                        sd_timeout <= 1'b0;
                        byte_cnt   <= 8'd0;
                        if (sd_cmd == CMD_INIT) begin
                            spi_cs_n <= 1'b1;
                        end
                        if (sd_cmd == CMD_SEL) begin
                            spi_cs_n <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    shreg    <= load_byte;
                    spi_mosi <= load_byte[7];
                    slow_sel <= (cmd_q == CMD_INIT);
                    div_cnt  <= '0;
                    bit_cnt  <= 3'd0;
                end
                BIT_LO: begin
                    if (phase_end) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        rx_sh    <= {rx_sh[6:0], spi_miso};
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                BIT_HI: begin
                    if (phase_end) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        if (last_bit) begin
                            sd_din <= rx_sh;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            shreg    <= {shreg[6:0], 1'b0};
                            spi_mosi <= shreg[6];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                BYTE_END: begin
                    if (cmd_done) begin
                        spi_mosi <= 1'b1;
                        if (cmd_q == CMD_POLL && !poll_hit && poll_out) begin
                            sd_timeout <= 1'b1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Bench for sd_spi_engine: SPI slave model, vector table,
// directed corner sequences and randomized commands.
module tb_sd_spi_engine;

    localparam int SLOW      = 64;
    localparam int FAST      = 2;
    localparam int NINIT     = 10;
    localparam int PMAX      = 255;
    localparam int BYTE_FAST = 16 * FAST + 2;
    localparam int BYTE_SLOW = 16 * SLOW + 2;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       sd_signal = 1'b0;
    logic [1:0] sd_cmd    = 2'd0;
    logic [7:0] sd_out    = 8'd0;
    logic       spi_miso  = 1'b1;
    logic [7:0] sd_din;
    logic       sd_busy;
    logic       sd_timeout;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;

    always #5 clock = ~clock;

    sd_spi_engine #(
        .SLOW_DIV(SLOW), .FAST_DIV(FAST),
        .INIT_BYTES(NINIT), .POLL_MAX(PMAX)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
        .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Written by the main sequence only.
    logic [7:0] resp_arr [0:15];
    int         resp_len   = 0;
    logic [7:0] stuck_byte = 8'hFF;
    int         arm_seq    = 0;
    int         exp_div    = FAST;

    // Written by the slave/monitor only.
    int         arm_seen      = 0;
    int         ridx          = 0;
    int         bitpos        = 0;
    int         rises         = 0;
    int         bytes_clocked = 0;
    int         mosi_zeros    = 0;
    int         hi_len        = 0;
    int         hi_bad        = 0;
    logic [7:0] cur_byte      = 8'hFF;
    logic [7:0] mosi_acc      = 8'h00;
    logic [7:0] last_mosi     = 8'h00;
    logic       sclk_prev     = 1'b0;

    // SPI mode-0 slave: shifts response bytes MSB first, records MOSI.
    always @(posedge clock) begin
        #1;
        if (arm_seq != arm_seen) begin
            arm_seen = arm_seq;
            bitpos   = 0;
            cur_byte = (resp_len > 0) ? resp_arr[0] : stuck_byte;
            ridx     = 1;
            spi_miso = cur_byte[7];
        end
        if (spi_sclk && !sclk_prev) begin
            rises++;
            hi_len   = 0;
            mosi_acc = {mosi_acc[6:0], spi_mosi};
            if (!spi_mosi) mosi_zeros++;
            bitpos++;
            if (bitpos == 8) begin
                bitpos    = 0;
                last_mosi = mosi_acc;
                bytes_clocked++;
                cur_byte = (ridx < resp_len) ? resp_arr[ridx[3:0]] : stuck_byte;
                ridx++;
            end
            spi_miso = cur_byte[3'(7 - bitpos)];
        end
        if (spi_sclk) hi_len++;
        if (!spi_sclk && sclk_prev && hi_len != exp_div) hi_bad++;
        sclk_prev = spi_sclk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [7:0] o,
                          input int glitch, output int busy_n,
                          output logic to_first, output logic to_last,
                          output int cs_low);
        @(negedge clock);
        arm_seq++;
        sd_signal = 1'b1;
        sd_cmd    = c;
        sd_out    = o;
        @(negedge clock);
        sd_signal = 1'b0;
        busy_n    = 0;
        cs_low    = 0;
        to_first  = sd_timeout;
        to_last   = 1'b0;
        while (sd_busy && busy_n < 20000) begin
            busy_n++;
            to_last = sd_timeout;
            if (!spi_cs_n) cs_low++;
            sd_signal = (busy_n == glitch);
            if (busy_n == glitch) begin
                sd_cmd = 2'd1;
                sd_out = 8'h00;
            end
            @(negedge clock);
        end
        sd_signal = 1'b0;
        if (sd_busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_bound: busy still 1 after %0d clocks, required 0",
                     busy_n);
        end
    endtask

    // Poll outcome from the response list: first non-FF byte wins.
    function automatic void poll_model(output int nb, output logic [7:0] din,
                                       output logic to);
        logic [7:0] b;
        nb  = PMAX;
        din = 8'hFF;
        to  = 1'b1;
        for (int i = 0; i < PMAX; i++) begin
            b = (i < resp_len) ? resp_arr[i[3:0]] : stuck_byte;
            if (b != 8'hFF) begin
                nb  = i + 1;
                din = b;
                to  = 1'b0;
                break;
            end
        end
    endfunction

    typedef struct {
        logic [7:0] tx;
        logic [7:0] miso;
        logic [7:0] exp_din;
        logic [7:0] exp_mosi;
        int         exp_busy;
    } vec_t;

    vec_t vt [5];

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, sd_busy, 0);
        chk({tag, "_timeout"}, sd_timeout, 0);
        chk({tag, "_din"}, sd_din, 8'hFF);
        chk({tag, "_cs_n"}, spi_cs_n, 1);
        chk({tag, "_sclk"}, spi_sclk, 0);
        chk({tag, "_mosi"}, spi_mosi, 1);
    endtask

    initial begin
        int         bn;
        int         cl;
        int         r0;
        int         b0;
        int         z0;
        int         h0;
        int         nb;
        int         n;
        logic       tf;
        logic       tl;
        logic       to_m;
        logic       cs_model;
        logic [1:0] c;
        logic [7:0] o;
        logic [7:0] din_model;
        logic [7:0] d_m;

        vt[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 34};
        vt[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 34};
        vt[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 34};
        vt[3] = '{8'h80, 8'h01, 8'h01, 8'h80, 34};
        vt[4] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A, 34};

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_state("reset");
        reset_n = 1'b1;

        r0 = rises;
        do_cmd(2'd2, 8'h00, -1, bn, tf, tl, cl);
        chk("sel_busy", bn, 1);
        chk("sel_cs_n", spi_cs_n, 0);
        chk("sel_no_sclk", rises - r0, 0);

        for (int i = 0; i < 5; i++) begin
            resp_arr[0] = vt[i].miso;
            resp_len    = 1;
            r0          = rises;
            do_cmd(2'd1, vt[i].tx, -1, bn, tf, tl, cl);
            chk("xchg_din", sd_din, vt[i].exp_din);
            chk("xchg_mosi", last_mosi, vt[i].exp_mosi);
            chk("xchg_busy", bn, vt[i].exp_busy);
            chk("xchg_rises", rises - r0, 8);
            chk("xchg_cs_n", spi_cs_n, 0);
        end

        resp_arr[0] = 8'h96;
        resp_len    = 1;
        r0          = rises;
        do_cmd(2'd1, 8'h5A, 10, bn, tf, tl, cl);
        chk("ign_busy", bn, 34);
        chk("ign_din", sd_din, 8'h96);
        chk("ign_mosi", last_mosi, 8'h5A);
        repeat (6) @(negedge clock);
        chk("ign_not_queued", sd_busy, 0);
        chk("ign_rises", rises - r0, 8);

        resp_arr[0] = 8'hFF;
        resp_arr[1] = 8'hFF;
        resp_arr[2] = 8'hFF;
        resp_arr[3] = 8'h01;
        resp_len    = 4;
        b0          = bytes_clocked;
        do_cmd(2'd3, 8'h00, -1, bn, tf, tl, cl);
        chk("poll4_bytes", bytes_clocked - b0, 4);
        chk("poll4_din", sd_din, 8'h01);
        chk("poll4_timeout", sd_timeout, 0);
        chk("poll4_busy", bn, 4 * BYTE_FAST);

        resp_len = 0;
        b0       = bytes_clocked;
        do_cmd(2'd3, 8'h00, -1, bn, tf, tl, cl);
        chk("pollto_bytes", bytes_clocked - b0, PMAX);
        chk("pollto_din", sd_din, 8'hFF);
        chk("pollto_timeout", sd_timeout, 1);
        chk("pollto_to_before_fall", tl, 0);
        chk("pollto_busy", bn, PMAX * BYTE_FAST);

        resp_arr[0] = 8'h77;
        resp_len    = 1;
        do_cmd(2'd1, 8'h11, -1, bn, tf, tl, cl);
        chk("to_clear_on_accept", tf, 0);
        chk("to_clear_din", sd_din, 8'h77);

        cs_model  = 1'b0;
        din_model = 8'h77;
        for (int it = 0; it < 14; it++) begin
            c = 2'($urandom_range(1, 3));
            o = 8'($urandom);
            if (c == 2'd3) begin
                n = $urandom_range(1, 8);
                for (int k = 0; k < n - 1; k++) begin
                    resp_arr[k] = ($urandom % 4 == 0) ? 8'($urandom) : 8'hFF;
                end
                resp_arr[n - 1] = 8'($urandom_range(0, 254));
                resp_len = n;
            end else begin
                resp_arr[0] = 8'($urandom);
                resp_len    = 1;
            end
            to_m = 1'b0;
            case (c)
                2'd1: begin
                    nb        = 1;
                    din_model = resp_arr[0];
                end
                2'd2: begin
                    nb       = 0;
                    cs_model = 1'b0;
                end
                default: begin
                    poll_model(nb, d_m, to_m);
                    din_model = d_m;
                end
            endcase
            b0 = bytes_clocked;
            do_cmd(c, o, -1, bn, tf, tl, cl);
            chk("rnd_din", sd_din, din_model);
            chk("rnd_timeout", sd_timeout, to_m);
            chk("rnd_bytes", bytes_clocked - b0, nb);
            chk("rnd_busy", bn, (c == 2'd2) ? 1 : nb * BYTE_FAST);
            chk("rnd_cs_n", spi_cs_n, cs_model);
            if (c == 2'd1) chk("rnd_mosi", last_mosi, o);
        end

        exp_div = SLOW;
        for (int k = 0; k < NINIT - 1; k++) resp_arr[k] = 8'hFF;
        resp_arr[NINIT - 1] = 8'h42;
        resp_len = NINIT;
        r0 = rises;
        z0 = mosi_zeros;
        h0 = hi_bad;
        do_cmd(2'd0, 8'h00, -1, bn, tf, tl, cl);
        chk("init_rises", rises - r0, 8 * NINIT);
        chk("init_cs_low", cl, 0);
        chk("init_mosi_low", mosi_zeros - z0, 0);
        chk("init_hi_len", hi_bad - h0, 0);
        chk("init_busy", bn, NINIT * BYTE_SLOW);
        chk("init_din", sd_din, 8'h42);
        chk("init_cs_n_after", spi_cs_n, 1);

        @(negedge clock);
        arm_seq++;
        sd_signal = 1'b1;
        sd_cmd    = 2'd0;
        @(negedge clock);
        sd_signal = 1'b0;
        repeat (300) @(negedge clock);
        chk("mid_busy", sd_busy, 1);
        reset_n = 1'b0;
        @(negedge clock);
        chk_reset_state("midrst");
        reset_n = 1'b1;
        r0 = rises;
        repeat (200) @(negedge clock);
        chk("midrst_no_sclk", rises - r0, 0);
        chk("midrst_idle", sd_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
